// File: rtl/pkt_bufid_refcnt_manager_if.sv
// Handshake bundle between the forwarding stage, the transmit-release ports,
// the free-bufid pool and the bufid reference-count manager.
interface pkt_bufid_refcnt_manager_if #(
   parameter int BUFID_WIDTH = 9,
   parameter int CNT_WIDTH   = 4
);
   logic [BUFID_WIDTH-1:0] iv_pkt_bufid;
   logic [CNT_WIDTH-1:0]   iv_pkt_bufid_cnt;
   logic                   i_pkt_bufid_req;
   logic                   o_pkt_bufid_ack;
   logic [BUFID_WIDTH-1:0] iv_release_bufid;
   logic                   i_release_req;
   logic                   o_release_ack;
   logic [BUFID_WIDTH-1:0] ov_free_bufid;
   logic                   o_free_bufid_wr;
   logic                   i_free_bufid_ready;
   logic [BUFID_WIDTH:0]   ov_used_bufid_num;
   logic [15:0]            ov_err_cnt;

   modport master (
      output iv_pkt_bufid, iv_pkt_bufid_cnt, i_pkt_bufid_req,
      output iv_release_bufid, i_release_req, i_free_bufid_ready,
      input  o_pkt_bufid_ack, o_release_ack, ov_free_bufid, o_free_bufid_wr,
      input  ov_used_bufid_num, ov_err_cnt
   );

   modport slave (
      input  iv_pkt_bufid, iv_pkt_bufid_cnt, i_pkt_bufid_req,
      input  iv_release_bufid, i_release_req, i_free_bufid_ready,
      output o_pkt_bufid_ack, o_release_ack, ov_free_bufid, o_free_bufid_wr,
      output ov_used_bufid_num, ov_err_cnt
   );
endinterface

// File: rtl/pkt_bufid_refcnt_manager.sv
// Per-bufid reference counter: set copy count, decrement per release, return bufid to pool at zero.
// Optional protocol error counter enabled by defining REFCNT_ERR_CNT_EN.
module pkt_bufid_refcnt_manager #(
   parameter int BUFID_WIDTH = 9,
   parameter int CNT_WIDTH   = 4
) (
   input logic i_clk,
   input logic i_rst,
   pkt_bufid_refcnt_manager_if.slave bus
);
   localparam int DEPTH = 2**BUFID_WIDTH;
   localparam logic [BUFID_WIDTH:0] USED_MAX = (BUFID_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACK_HOLD, FREE_WAIT} state_t;

   function automatic logic [BUFID_WIDTH:0] used_inc(input logic [BUFID_WIDTH:0] v);
      return (v == USED_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [BUFID_WIDTH:0] used_dec(input logic [BUFID_WIDTH:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q [DEPTH];
   logic                   pkt_ack_q, pkt_ack_d;
   logic                   rel_ack_q, rel_ack_d;
   logic                   free_wr_q, free_wr_d;
   logic [BUFID_WIDTH-1:0] free_bufid_q, free_bufid_d;
   logic [BUFID_WIDTH:0]   used_q, used_d;
   logic                   tbl_we;
   logic [BUFID_WIDTH-1:0] tbl_wa;
   logic [CNT_WIDTH-1:0]   tbl_wd;
   logic [CNT_WIDTH-1:0]   set_old, rel_old;

   assign set_old = cnt_q[bus.iv_pkt_bufid];
   assign rel_old = cnt_q[bus.iv_release_bufid];

   always_comb begin
      state_d      = state_q;
      pkt_ack_d    = 1'b0;
      rel_ack_d    = 1'b0;
      free_wr_d    = free_wr_q;
      free_bufid_d = free_bufid_q;
      used_d       = used_q;
      tbl_we       = 1'b0;
      tbl_wa       = '0;
      tbl_wd       = '0;
      case (state_q)
         IDLE: begin
            // Set wins over release; a losing release stays pending on its req line.
            if (bus.i_pkt_bufid_req) begin
               pkt_ack_d = 1'b1;
               if (bus.iv_pkt_bufid_cnt != '0) begin
                  tbl_we  = 1'b1;
                  tbl_wa  = bus.iv_pkt_bufid;
                  tbl_wd  = bus.iv_pkt_bufid_cnt;
                  if (set_old == '0) used_d = used_inc(used_q);
                  state_d = ACK_HOLD;
               end else begin
                  free_wr_d    = 1'b1;
                  free_bufid_d = bus.iv_pkt_bufid;
                  state_d      = FREE_WAIT;
               end
            end else if (bus.i_release_req) begin
               rel_ack_d = 1'b1;
               if (rel_old > CNT_WIDTH'(1)) begin
                  tbl_we  = 1'b1;
                  tbl_wa  = bus.iv_release_bufid;
                  tbl_wd  = rel_old - 1'b1;
                  state_d = ACK_HOLD;
               end else if (rel_old == CNT_WIDTH'(1)) begin
                  tbl_we       = 1'b1;
                  tbl_wa       = bus.iv_release_bufid;
                  tbl_wd       = '0;
                  used_d       = used_dec(used_q);
                  free_wr_d    = 1'b1;
                  free_bufid_d = bus.iv_release_bufid;
                  state_d      = FREE_WAIT;
               end else begin
                  state_d = ACK_HOLD;
               end
            end
         end
         ACK_HOLD: state_d = IDLE;
         FREE_WAIT: begin
            if (free_wr_q && bus.i_free_bufid_ready) begin
               free_wr_d    = 1'b0;
               free_bufid_d = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         pkt_ack_q    <= 1'b0;
         rel_ack_q    <= 1'b0;
         free_wr_q    <= 1'b0;
         free_bufid_q <= '0;
         used_q       <= '0;
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         pkt_ack_q    <= pkt_ack_d;
         rel_ack_q    <= rel_ack_d;
         free_wr_q    <= free_wr_d;
         free_bufid_q <= free_bufid_d;
         used_q       <= used_d;
         if (tbl_we) cnt_q[tbl_wa] <= tbl_wd;
      end
   end

   assign bus.o_pkt_bufid_ack   = pkt_ack_q;
   assign bus.o_release_ack     = rel_ack_q;
   assign bus.o_free_bufid_wr   = free_wr_q;
   assign bus.ov_free_bufid     = free_bufid_q;
   assign bus.ov_used_bufid_num = used_q;

`ifdef REFCNT_ERR_CNT_EN
   logic [15:0] err_q, err_d;
   logic        err_evt;

   // Errors: overwriting a live count, or releasing a bufid that holds no copies.
   assign err_evt = (state_q == IDLE) &&
                    ((bus.i_pkt_bufid_req && (bus.iv_pkt_bufid_cnt != '0) && (set_old != '0)) ||
                     (!bus.i_pkt_bufid_req && bus.i_release_req && (rel_old == '0)));

   always_comb begin
      err_d = err_q;
      if (err_evt && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 16'h0;
      else       err_q <= err_d;
   end

   assign bus.ov_err_cnt = err_q;
`else
   assign bus.ov_err_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_pkt_bufid_refcnt_manager.sv
// Directed bench for pkt_bufid_refcnt_manager: set/release/free sequences with hand-computed expectations.
module tb_pkt_bufid_refcnt_manager;
   localparam int BW = 9;
   localparam int CW = 4;
`ifdef REFCNT_ERR_CNT_EN
   localparam logic [15:0] ERR_EXP = 16'd2;
`else
   localparam logic [15:0] ERR_EXP = 16'd0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #4 clk = ~clk;

   pkt_bufid_refcnt_manager_if #(.BUFID_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

   pkt_bufid_refcnt_manager #(.BUFID_WIDTH(BW), .CNT_WIDTH(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_set(input logic [BW-1:0] b, input logic [CW-1:0] c);
      bus.iv_pkt_bufid     = b;
      bus.iv_pkt_bufid_cnt = c;
      bus.i_pkt_bufid_req  = 1'b1;
      tick();
      bus.i_pkt_bufid_req  = 1'b0;
   endtask

   task automatic send_rel(input logic [BW-1:0] b);
      bus.iv_release_bufid = b;
      bus.i_release_req    = 1'b1;
      tick();
      bus.i_release_req    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b0 || bus.o_release_ack !== 1'b0 || bus.o_free_bufid_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got ack=%b rack=%b wr=%b want 0 0 0", bus.o_pkt_bufid_ack, bus.o_release_ack, bus.o_free_bufid_wr);
      end
      n_tests++;
      if (bus.ov_free_bufid !== 9'h0 || bus.ov_used_bufid_num !== 10'd0 || bus.ov_err_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got free=%h used=%0d err=%0d want 0 0 0", bus.ov_free_bufid, bus.ov_used_bufid_num, bus.ov_err_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_release_chain();
      bus.i_free_bufid_ready = 1'b1;
      send_set(9'h05, 4'd3);
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b1 || bus.ov_used_bufid_num !== 10'd1 || bus.o_free_bufid_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL chain_set: got ack=%b used=%0d wr=%b want 1 1 0", bus.o_pkt_bufid_ack, bus.ov_used_bufid_num, bus.o_free_bufid_wr);
      end
      tick();
      for (int k = 1; k <= 3; k++) begin
         send_rel(9'h05);
         n_tests++;
         if (bus.o_release_ack !== 1'b1 || bus.o_pkt_bufid_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL chain_rel_ack%0d: got rack=%b ack=%b want 1 0", k, bus.o_release_ack, bus.o_pkt_bufid_ack);
         end
         n_tests++;
         if (bus.o_free_bufid_wr !== (k == 3) || bus.ov_used_bufid_num !== ((k == 3) ? 10'd0 : 10'd1)) begin
            n_fail++;
            $display("FAIL chain_rel_free%0d: got wr=%b used=%0d want %b %0d", k, bus.o_free_bufid_wr, bus.ov_used_bufid_num, (k == 3), (k == 3) ? 0 : 1);
         end
         if (k == 3) begin
            n_tests++;
            if (bus.ov_free_bufid !== 9'h05) begin
               n_fail++;
               $display("FAIL chain_free_id: got %h want 005", bus.ov_free_bufid);
            end
         end
         tick();
      end
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b0 || bus.ov_free_bufid !== 9'h0) begin
         n_fail++;
         $display("FAIL chain_free_done: got wr=%b id=%h want 0 000", bus.o_free_bufid_wr, bus.ov_free_bufid);
      end
   endtask

   task automatic test_set_zero();
      send_set(9'h1FF, 4'd0);
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b1 || bus.ov_free_bufid !== 9'h1FF) begin
         n_fail++;
         $display("FAIL setzero_free: got ack=%b wr=%b id=%h want 1 1 1ff", bus.o_pkt_bufid_ack, bus.o_free_bufid_wr, bus.ov_free_bufid);
      end
      n_tests++;
      if (bus.ov_used_bufid_num !== 10'd0) begin
         n_fail++;
         $display("FAIL setzero_used: got %0d want 0", bus.ov_used_bufid_num);
      end
      tick();
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b0 || bus.o_pkt_bufid_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL setzero_done: got wr=%b ack=%b want 0 0", bus.o_free_bufid_wr, bus.o_pkt_bufid_ack);
      end
      send_rel(9'h1FF);
      n_tests++;
      if (bus.o_release_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL setzero_tbl: got rack=%b wr=%b want 1 0", bus.o_release_ack, bus.o_free_bufid_wr);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      bus.iv_pkt_bufid     = 9'h20;
      bus.iv_pkt_bufid_cnt = 4'd2;
      bus.iv_release_bufid = 9'h20;
      bus.i_pkt_bufid_req  = 1'b1;
      bus.i_release_req    = 1'b1;
      tick();
      bus.i_pkt_bufid_req  = 1'b0;
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b1 || bus.o_release_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_t1: got ack=%b rack=%b want 1 0", bus.o_pkt_bufid_ack, bus.o_release_ack);
      end
      tick();
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b0 || bus.o_release_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_t2: got ack=%b rack=%b want 0 0", bus.o_pkt_bufid_ack, bus.o_release_ack);
      end
      tick();
      bus.i_release_req = 1'b0;
      n_tests++;
      if (bus.o_release_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0 || bus.ov_used_bufid_num !== 10'd1) begin
         n_fail++;
         $display("FAIL simul_t3: got rack=%b wr=%b used=%0d want 1 0 1", bus.o_release_ack, bus.o_free_bufid_wr, bus.ov_used_bufid_num);
      end
      tick();
      send_rel(9'h20);
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b1 || bus.ov_free_bufid !== 9'h20 || bus.ov_used_bufid_num !== 10'd0) begin
         n_fail++;
         $display("FAIL simul_last: got wr=%b id=%h used=%0d want 1 020 0", bus.o_free_bufid_wr, bus.ov_free_bufid, bus.ov_used_bufid_num);
      end
      tick();
   endtask

   task automatic test_ready_stall();
      bus.i_free_bufid_ready = 1'b0;
      send_set(9'h30, 4'd1);
      tick();
      send_rel(9'h30);
      for (int c = 1; c <= 5; c++) begin
         n_tests++;
         if (bus.o_free_bufid_wr !== 1'b1 || bus.ov_free_bufid !== 9'h30 || bus.o_release_ack !== (c == 1) || bus.o_pkt_bufid_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_c%0d: got wr=%b id=%h rack=%b ack=%b want 1 030 %b 0", c, bus.o_free_bufid_wr, bus.ov_free_bufid, bus.o_release_ack, bus.o_pkt_bufid_ack, (c == 1));
         end
         tick();
      end
      bus.i_free_bufid_ready = 1'b1;
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b1 || bus.ov_free_bufid !== 9'h30) begin
         n_fail++;
         $display("FAIL stall_c6: got wr=%b id=%h want 1 030", bus.o_free_bufid_wr, bus.ov_free_bufid);
      end
      tick();
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b0 || bus.ov_free_bufid !== 9'h0) begin
         n_fail++;
         $display("FAIL stall_done: got wr=%b id=%h want 0 000", bus.o_free_bufid_wr, bus.ov_free_bufid);
      end
   endtask

   task automatic test_errors();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send_rel(9'h10);
      n_tests++;
      if (bus.o_release_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL err_relzero: got rack=%b wr=%b want 1 0", bus.o_release_ack, bus.o_free_bufid_wr);
      end
      tick();
      send_set(9'h10, 4'd2);
      tick();
      send_set(9'h10, 4'd2);
      n_tests++;
      if (bus.o_pkt_bufid_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0 || bus.ov_used_bufid_num !== 10'd1) begin
         n_fail++;
         $display("FAIL err_reset_used: got ack=%b wr=%b used=%0d want 1 0 1", bus.o_pkt_bufid_ack, bus.o_free_bufid_wr, bus.ov_used_bufid_num);
      end
      tick();
      n_tests++;
      if (bus.ov_err_cnt !== ERR_EXP) begin
         n_fail++;
         $display("FAIL err_cnt: got %0d want %0d", bus.ov_err_cnt, ERR_EXP);
      end
   endtask

   task automatic test_reset_in_free_wait();
      bus.i_free_bufid_ready = 1'b0;
      send_set(9'h60, 4'd3);
      tick();
      send_set(9'h50, 4'd1);
      tick();
      send_rel(9'h50);
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b1 || bus.o_release_ack !== 1'b1 || bus.ov_used_bufid_num !== 10'd2) begin
         n_fail++;
         $display("FAIL rstfw_pre: got wr=%b rack=%b used=%0d want 1 1 2", bus.o_free_bufid_wr, bus.o_release_ack, bus.ov_used_bufid_num);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (bus.o_free_bufid_wr !== 1'b0 || bus.o_release_ack !== 1'b0 || bus.o_pkt_bufid_ack !== 1'b0 ||
          bus.ov_free_bufid !== 9'h0 || bus.ov_used_bufid_num !== 10'd0 || bus.ov_err_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL rstfw_out: got wr=%b rack=%b ack=%b id=%h used=%0d err=%0d want all 0", bus.o_free_bufid_wr, bus.o_release_ack, bus.o_pkt_bufid_ack, bus.ov_free_bufid, bus.ov_used_bufid_num, bus.ov_err_cnt);
      end
      bus.i_free_bufid_ready = 1'b1;
      send_rel(9'h60);
      n_tests++;
      if (bus.o_release_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL rstfw_tbl60: got rack=%b wr=%b want 1 0", bus.o_release_ack, bus.o_free_bufid_wr);
      end
      tick();
      send_rel(9'h05);
      n_tests++;
      if (bus.o_release_ack !== 1'b1 || bus.o_free_bufid_wr !== 1'b0 || bus.ov_used_bufid_num !== 10'd0) begin
         n_fail++;
         $display("FAIL rstfw_tbl05: got rack=%b wr=%b used=%0d want 1 0 0", bus.o_release_ack, bus.o_free_bufid_wr, bus.ov_used_bufid_num);
      end
      tick();
   endtask

   initial begin
      rst                    = 1'b1;
      bus.iv_pkt_bufid       = '0;
      bus.iv_pkt_bufid_cnt   = '0;
      bus.i_pkt_bufid_req    = 1'b0;
      bus.iv_release_bufid   = '0;
      bus.i_release_req      = 1'b0;
      bus.i_free_bufid_ready = 1'b1;
      test_reset();
      test_release_chain();
      test_set_zero();
      test_simultaneous();
      test_ready_stall();
      test_errors();
      test_reset_in_free_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
